// File: rtl/mips_commit_tracer.sv
// ============================================================================
//  Module      : mips_commit_tracer
//  Description : Retirement-trace FIFO for the single-cycle MIPS core.
//                Captures register writes and stores with PC and sequence
//                number; drained first-word-fall-through over valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_commit_tracer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Globalclk,
  input  logic          Globalreset,
  input  logic [31:0]   PCout,
  input  logic          RegWrite,
  input  logic [4:0]    WriteReg,
  input  logic [31:0]   WriteDatato_Reg,
  input  logic          MemWrite,
  input  logic [31:0]   aluout,
  input  logic [31:0]   ReadData2,
  input  logic          capture_en,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic          trace_kind,
  output logic [31:0]   trace_pc,
  output logic [31:0]   trace_addr,
  output logic [31:0]   trace_data,
  output logic [15:0]   trace_seq,
  output logic [AW:0]   count,
  output logic [15:0]   dropped
);

  // Entry layout: {kind, seq[15:0], pc[31:0], addr[31:0], data[31:0]}
  localparam int          c_EW   = 113;
  localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

  logic [c_EW-1:0] mem_q [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [AW:0]     count_q, count_d;
  logic [15:0]     seq_q, seq_d;
  logic [15:0]     dropped_q, dropped_d;

  logic            w_reg_ev;
  logic            w_ev;
  logic            w_pop;
  logic            w_push;
  logic [c_EW-1:0] w_entry;
  logic [c_EW-1:0] w_head;

  // Event qualification, entry formation and next-state for pointers/counters.
  // A register write to $0 is not an event; when both enables are high the
  // register write wins and the store is silently ignored.
  always_comb begin
    w_reg_ev  = RegWrite & (WriteReg != 5'd0);
    w_ev      = capture_en & (w_reg_ev | MemWrite);
    w_pop     = (count_q != '0) & trace_ready;
    w_push    = w_ev & ((count_q != c_FULL) | w_pop);
    w_entry   = w_reg_ev ? {1'b0, seq_q, PCout, {27'b0, WriteReg}, WriteDatato_Reg}
                         : {1'b1, seq_q, PCout, aluout, ReadData2};
    head_d    = w_pop  ? head_q + AW'(1) : head_q;
    tail_d    = w_push ? tail_q + AW'(1) : tail_q;
    seq_d     = w_push ? seq_q + 16'd1   : seq_q;
    count_d   = count_q;
    if (w_push && !w_pop)      count_d = count_q + (AW+1)'(1);
    else if (w_pop && !w_push) count_d = count_q - (AW+1)'(1);
    dropped_d = dropped_q;
    if (w_ev && !w_push && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge Globalclk or posedge Globalreset) begin
    if (Globalreset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      seq_q     <= '0;
      dropped_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      seq_q     <= seq_d;
      dropped_q <= dropped_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge Globalclk) begin
    if (w_push) mem_q[tail_q] <= w_entry;
  end

  // Head slot presented while non-empty, zeros otherwise. The head slot is
  // never the write target unless it is popped the same edge, so it holds.
  always_comb begin
    w_head      = (count_q != '0) ? mem_q[head_q] : '0;
    trace_valid = (count_q != '0);
    trace_kind  = w_head[112];
    trace_seq   = w_head[111:96];
    trace_pc    = w_head[95:64];
    trace_addr  = w_head[63:32];
    trace_data  = w_head[31:0];
    count       = count_q;
    dropped     = dropped_q;
  end

endmodule

`default_nettype wire
